// File: rtl/triangle_streamer_if.sv
// Job-control, mesh-memory and triangle-stream signals of the triangle streamer.
// The streamer drives the master side; the memory/FIFO/controller environment drives the slave side.
interface triangle_streamer_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  start_in;
    logic [ADDR_WIDTH-1:0] base_addr_in;
    logic [15:0]           tri_count_in;
    logic                  mem_en_out;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [127:0]          mem_data_in;
    logic                  position_valid_out;
    logic [3:0][31:0]      position_out;
    logic                  normal_valid_out;
    logic [2:0][31:0]      normal_out;
    logic                  material_valid_out;
    logic [11:0]           material_out;
    logic                  consumed_in;
    logic                  busy_out;
    logic                  done_out;

    modport master (
        input  start_in, base_addr_in, tri_count_in, mem_data_in, consumed_in,
        output mem_en_out, mem_addr_out, position_valid_out, position_out,
               normal_valid_out, normal_out, material_valid_out, material_out,
               busy_out, done_out
    );

    modport slave (
        output start_in, base_addr_in, tri_count_in, mem_data_in, consumed_in,
        input  mem_en_out, mem_addr_out, position_valid_out, position_out,
               normal_valid_out, normal_out, material_valid_out, material_out,
               busy_out, done_out
    );
endinterface

// File: rtl/triangle_streamer.sv
// Streams two-word triangles from mesh memory into a downstream FIFO, issuing
// a triangle only while the FIFO has a free slot according to a credit counter.
module triangle_streamer #(
    parameter int FIFO_DEPTH  = 1024,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    triangle_streamer_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int ML = MEM_LATENCY;
    localparam logic [CW-1:0] CREDITS_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           left_q, left_d;
    logic                  phase_q, phase_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic [ML-1:0]         tagValid_q, tagValid_d;
    logic [ML-1:0]         tagWord1_q, tagWord1_d;
    logic                  posValid_q, posValid_d;
    logic [3:0][31:0]      position_q, position_d;
    logic                  nrmValid_q, nrmValid_d;
    logic [2:0][31:0]      normal_q, normal_d;
    logic [11:0]           material_q, material_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  issueWord0, issueWord1, issue, consumeOk;

    always_comb begin
        issueWord0 = (state_q == FETCH) && !phase_q && (credits_q != '0);
        issueWord1 = (state_q == FETCH) && phase_q;
        issue      = issueWord0 || issueWord1;
        consumeOk  = bus.consumed_in && (credits_q != CREDITS_FULL);

        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        phase_d    = phase_q;
        busy_d     = done_q ? 1'b0 : busy_q;
        done_d     = 1'b0;
        posValid_d = 1'b0;
        nrmValid_d = 1'b0;
        position_d = position_q;
        normal_d   = normal_q;
        material_d = material_q;
        credits_d  = credits_q - CW'(issueWord0) + CW'(consumeOk);

        // Tags follow each read so the returning word is routed by type, MEM_LATENCY cycles later.
        tagValid_d = (tagValid_q << 1) | ML'(issue);
        tagWord1_d = (tagWord1_q << 1) | ML'(issueWord1);

        if (tagValid_q[ML-1]) begin
            if (tagWord1_q[ML-1]) begin
                normal_d   = bus.mem_data_in[127:32];
                material_d = bus.mem_data_in[11:0];
                nrmValid_d = 1'b1;
            end else begin
                position_d = bus.mem_data_in;
                posValid_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    if (bus.tri_count_in != 16'd0) begin
                        state_d = FETCH;
                        addr_d  = bus.base_addr_in;
                        left_d  = bus.tri_count_in;
                        phase_d = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (issue) begin
                    addr_d  = addr_q + 1'b1;
                    phase_d = ~phase_q;
                end
                if (issueWord1) begin
                    left_d = left_q - 16'd1;
                    if (left_q == 16'd1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // With no reads left in flight, this normal strobe is the job's last.
                if (nrmValid_q && (tagValid_q == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            left_q     <= '0;
            phase_q    <= 1'b0;
            credits_q  <= CREDITS_FULL;
            tagValid_q <= '0;
            tagWord1_q <= '0;
            posValid_q <= 1'b0;
            position_q <= '0;
            nrmValid_q <= 1'b0;
            normal_q   <= '0;
            material_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            phase_q    <= phase_d;
            credits_q  <= credits_d;
            tagValid_q <= tagValid_d;
            tagWord1_q <= tagWord1_d;
            posValid_q <= posValid_d;
            position_q <= position_d;
            nrmValid_q <= nrmValid_d;
            normal_q   <= normal_d;
            material_q <= material_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.mem_en_out         = issue;
    assign bus.mem_addr_out       = addr_q;
    assign bus.position_valid_out = posValid_q;
    assign bus.position_out       = position_q;
    assign bus.normal_valid_out   = nrmValid_q;
    assign bus.normal_out         = normal_q;
    assign bus.material_valid_out = nrmValid_q;
    assign bus.material_out       = material_q;
    assign bus.busy_out           = busy_q;
    assign bus.done_out           = done_q;
endmodule

// File: tb/tb_triangle_streamer.sv
// Bench for triangle_streamer: a mesh memory with fixed read latency, a logging monitor,
// and per-scenario tasks that compare the logs with addresses and words derived from the job.
module tb_triangle_streamer;
    localparam int DEPTH = 4;
    localparam int ML    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    triangle_streamer_if #(.ADDR_WIDTH(16)) bus();

    triangle_streamer #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(16), .MEM_LATENCY(ML)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0     = 0;
    int skew   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Deterministic mesh contents: every word is a recognisable function of its address.
    function automatic logic [127:0] memWord(input logic [15:0] a);
        return {16'hC0DE, a, ~a, 16'h1234, a ^ 16'h5A5A, a + 16'd7, 8'h3C, a, 8'hE1};
    endfunction

    logic [15:0] pipeA [ML];
    logic        pipeV [ML] = '{default: 1'b0};
    always @(posedge clk) begin
        pipeA[0] <= bus.mem_addr_out;
        pipeV[0] <= bus.mem_en_out;
        for (int k = 1; k < ML; k++) begin
            pipeA[k] <= pipeA[k-1];
            pipeV[k] <= pipeV[k-1];
        end
    end
    assign bus.mem_data_in = pipeV[ML-1] ? memWord(pipeA[ML-1]) : {4{32'hDEADBEEF}};

    logic [15:0]  aQ[$];
    int           aC[$];
    logic [127:0] pQ[$];
    int           pC[$];
    logic [95:0]  nQ[$];
    logic [11:0]  mQ[$];
    int           nC[$];
    int           dC[$];
    int           bC[$];

    task automatic clearLogs();
        aQ.delete(); aC.delete(); pQ.delete(); pC.delete();
        nQ.delete(); mQ.delete(); nC.delete(); dC.delete(); bC.delete();
    endtask

    // One clock: log the cycle's outputs mid-cycle, then step to just after the next edge.
    task automatic tick();
        @(negedge clk);
        if (bus.mem_en_out) begin aQ.push_back(bus.mem_addr_out); aC.push_back(cyc); end
        if (bus.position_valid_out) begin pQ.push_back(bus.position_out); pC.push_back(cyc); end
        if (bus.normal_valid_out) begin
            nQ.push_back(bus.normal_out); mQ.push_back(bus.material_out); nC.push_back(cyc);
        end
        if (bus.material_valid_out !== bus.normal_valid_out) skew++;
        if (bus.done_out) dC.push_back(cyc);
        if (bus.busy_out) bC.push_back(cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic startJob(input logic [15:0] b, input logic [15:0] n);
        bus.start_in     = 1'b1;
        bus.base_addr_in = b;
        bus.tri_count_in = n;
        t0 = cyc;
        tick();
        bus.start_in = 1'b0;
    endtask

    task automatic giveBack(input int n);
        for (int k = 0; k < n; k++) begin
            bus.consumed_in = 1'b1;
            tick();
        end
        bus.consumed_in = 1'b0;
    endtask

    task automatic waitDone(input int bound);
        for (int k = 0; k < bound && dC.size() == 0; k++) tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_en_out !== 1'b0 || bus.mem_addr_out !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_mem: got en=%b addr=%h expected en=0 addr=0000", bus.mem_en_out, bus.mem_addr_out);
        end
        checks++;
        if (bus.position_valid_out !== 1'b0 || bus.position_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_position: got v=%b d=%h expected all 0", bus.position_valid_out, bus.position_out);
        end
        checks++;
        if (bus.normal_valid_out !== 1'b0 || bus.material_valid_out !== 1'b0 || bus.normal_out !== '0 || bus.material_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_normal: got nv=%b mv=%b n=%h m=%h expected all 0", bus.normal_valid_out, bus.material_valid_out, bus.normal_out, bus.material_out);
        end
        checks++;
        if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: got busy=%b done=%b expected 0 0", bus.busy_out, bus.done_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [127:0] w1;
        w1 = memWord(16'h0011);
        clearLogs();
        startJob(16'h0010, 16'd1);
        repeat (8) tick();
        checks++;
        if (aQ.size() != 2 || aQ[0] !== 16'h0010 || aC[0] != t0 + 1 || aQ[1] !== 16'h0011 || aC[1] != t0 + 2) begin
            errors++;
            $display("[TB] FAIL single_reads: got %0d reads first=%h@%0d expected 0010@%0d,0011@%0d", aQ.size(), aQ[0], aC[0], t0 + 1, t0 + 2);
        end
        checks++;
        if (pC.size() != 1 || pC[0] != t0 + 4 || pQ[0] !== memWord(16'h0010)) begin
            errors++;
            $display("[TB] FAIL single_position: got %0d strobes first@%0d expected 1 @%0d", pC.size(), pC[0], t0 + 4);
        end
        checks++;
        if (nC.size() != 1 || nC[0] != t0 + 5 || nQ[0] !== w1[127:32] || mQ[0] !== w1[11:0]) begin
            errors++;
            $display("[TB] FAIL single_normal: got %0d strobes first@%0d mat=%h expected 1 @%0d mat=%h", nC.size(), nC[0], mQ[0], t0 + 5, w1[11:0]);
        end
        checks++;
        if (dC.size() != 1 || dC[0] != t0 + 6) begin
            errors++;
            $display("[TB] FAIL single_done: got %0d pulses first@%0d expected 1 @%0d", dC.size(), dC[0], t0 + 6);
        end
        checks++;
        if (bC.size() != 6 || bC[0] != t0 + 1 || bC[$] != t0 + 6) begin
            errors++;
            $display("[TB] FAIL single_busy: got %0d cycles expected cycles %0d..%0d", bC.size(), t0 + 1, t0 + 6);
        end
        giveBack(1);
    endtask

    task automatic test_zero();
        clearLogs();
        startJob(16'($urandom), 16'd0);
        repeat (5) tick();
        checks++;
        if (dC.size() != 1 || dC[0] != t0 + 1) begin
            errors++;
            $display("[TB] FAIL zero_done: got %0d pulses first@%0d expected 1 @%0d", dC.size(), dC[0], t0 + 1);
        end
        checks++;
        if (aQ.size() + bC.size() + pC.size() + nC.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_quiet: got reads=%0d busy=%0d pos=%0d nrm=%0d expected all 0", aQ.size(), bC.size(), pC.size(), nC.size());
        end
    endtask

    task automatic test_credit_stall();
        logic [15:0] b;
        int bad;
        b = 16'($urandom);
        clearLogs();
        startJob(b, 16'd6);
        repeat (20) tick();
        checks++;
        if (pC.size() != DEPTH || aQ.size() != 2 * DEPTH || dC.size() != 0) begin
            errors++;
            $display("[TB] FAIL stall_hold: got pos=%0d reads=%0d done=%0d expected %0d %0d 0", pC.size(), aQ.size(), dC.size(), DEPTH, 2 * DEPTH);
        end
        giveBack(2);
        waitDone(60);
        bad = 0;
        for (int k = 0; k < aQ.size(); k++) if (aQ[k] !== 16'(b + k)) bad++;
        for (int k = 0; k < pQ.size(); k++) if (pQ[k] !== memWord(16'(b + 2 * k))) bad++;
        checks++;
        if (pC.size() != 6 || aQ.size() != 12 || dC.size() != 1 || bad != 0) begin
            errors++;
            $display("[TB] FAIL stall_resume: got pos=%0d reads=%0d done=%0d bad=%0d expected 6 12 1 0", pC.size(), aQ.size(), dC.size(), bad);
        end
        giveBack(DEPTH + 2);
    endtask

    task automatic test_saturate();
        clearLogs();
        startJob(16'($urandom), 16'd5);
        repeat (25) tick();
        checks++;
        if (pC.size() != DEPTH) begin
            errors++;
            $display("[TB] FAIL saturate_limit: got %0d positions expected %0d", pC.size(), DEPTH);
        end
        giveBack(1);
        waitDone(40);
        checks++;
        if (pC.size() != 5 || dC.size() != 1) begin
            errors++;
            $display("[TB] FAIL saturate_finish: got pos=%0d done=%0d expected 5 1", pC.size(), dC.size());
        end
        giveBack(DEPTH);
    endtask

    task automatic test_simultaneous();
        clearLogs();
        startJob(16'($urandom), 16'd3);
        waitDone(40);
        clearLogs();
        startJob(16'h7FFE, 16'd2);
        bus.consumed_in = 1'b1;
        tick();
        bus.consumed_in = 1'b0;
        waitDone(40);
        checks++;
        if (aQ.size() != 4 || aC[3] != t0 + 4 || aQ[3] !== 16'h8001 || dC.size() != 1) begin
            errors++;
            $display("[TB] FAIL simultaneous: got reads=%0d last@%0d=%h done=%0d expected 4 last@%0d=8001 1", aQ.size(), aC[3], aQ[3], dC.size(), t0 + 4);
        end
        giveBack(DEPTH);
    endtask

    task automatic test_reset_mid_job();
        logic [15:0] b;
        b = 16'($urandom);
        clearLogs();
        startJob(b, 16'd8);
        tick();
        tick();
        rst = 1'b1;
        bus.start_in = 1'b1;
        bus.consumed_in = 1'b1;
        tick();
        rst = 1'b0;
        bus.start_in = 1'b0;
        bus.consumed_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_en_out, bus.position_valid_out, bus.normal_valid_out, bus.material_valid_out, bus.busy_out, bus.done_out} !== 6'b0
            || bus.mem_addr_out !== 16'h0 || bus.position_out !== '0 || bus.normal_out !== '0 || bus.material_out !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got en=%b pv=%b nv=%b busy=%b addr=%h expected all 0", bus.mem_en_out, bus.position_valid_out, bus.normal_valid_out, bus.busy_out, bus.mem_addr_out);
        end
        @(posedge clk);
        #1;
        clearLogs();
        repeat (10) tick();
        checks++;
        if (aQ.size() + pC.size() + nC.size() + dC.size() + bC.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_stale: got reads=%0d pos=%0d nrm=%0d done=%0d busy=%0d expected all 0", aQ.size(), pC.size(), nC.size(), dC.size(), bC.size());
        end
        clearLogs();
        startJob(b, 16'd4);
        repeat (12) tick();
        checks++;
        if (aQ.size() != 8 || aC[7] != t0 + 8 || dC.size() != 1) begin
            errors++;
            $display("[TB] FAIL midreset_credits: got reads=%0d last@%0d done=%0d expected 8 @%0d 1", aQ.size(), aC[7], dC.size(), t0 + 8);
        end
        giveBack(DEPTH);
    endtask

    task automatic test_restart();
        logic [15:0] b;
        int bad;
        b = 16'($urandom);
        clearLogs();
        startJob(b, 16'd4);
        tick();
        tick();
        bus.start_in = 1'b1;
        bus.base_addr_in = b ^ 16'h5555;
        bus.tri_count_in = 16'd3;
        tick();
        bus.start_in = 1'b0;
        waitDone(60);
        bad = 0;
        for (int k = 0; k < aQ.size(); k++) if (aQ[k] !== 16'(b + k)) bad++;
        for (int k = 0; k < pQ.size(); k++) if (pQ[k] !== memWord(16'(b + 2 * k))) bad++;
        checks++;
        if (aQ.size() != 8 || pC.size() != 4 || dC.size() != 1 || bad != 0) begin
            errors++;
            $display("[TB] FAIL restart_ignored: got reads=%0d pos=%0d done=%0d bad=%0d expected 8 4 1 0", aQ.size(), pC.size(), dC.size(), bad);
        end
        giveBack(DEPTH);
    endtask

    task automatic test_random_jobs();
        logic [15:0]  b;
        logic [127:0] w;
        int n, got, badA, badD, badT;
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 7);
            b = (j == 0) ? 16'hFFFB : 16'($urandom);
            clearLogs();
            skew = 0;
            got = 0;
            startJob(b, 16'(n));
            for (int c = 0; c < 400 && dC.size() == 0; c++) begin
                bus.consumed_in = (pC.size() > got) && ($urandom_range(0, 2) == 0);
                tick();
                if (bus.consumed_in) got++;
            end
            bus.consumed_in = 1'b0;
            tick();
            tick();
            badA = 0; badD = 0; badT = 0;
            for (int k = 0; k < aQ.size(); k++) if (aQ[k] !== 16'(b + k)) badA++;
            for (int k = 0; k < pQ.size(); k++) if (pQ[k] !== memWord(16'(b + 2 * k))) badD++;
            for (int k = 0; k < nQ.size(); k++) begin
                w = memWord(16'(b + 2 * k + 1));
                if (nQ[k] !== w[127:32] || mQ[k] !== w[11:0]) badD++;
            end
            for (int k = 0; k < pC.size(); k++) begin
                if (2 * k + 1 >= aC.size() || aC[2 * k + 1] != aC[2 * k] + 1 || pC[k] != aC[2 * k] + ML + 1) badT++;
                if (k >= nC.size() || nC[k] != pC[k] + 1) badT++;
            end
            checks++;
            if (aQ.size() != 2 * n || badA != 0) begin
                errors++;
                $display("[TB] FAIL random_addr job%0d: got %0d reads bad=%0d expected %0d bad=0", j, aQ.size(), badA, 2 * n);
            end
            checks++;
            if (pC.size() != n || nC.size() != n || badD != 0) begin
                errors++;
                $display("[TB] FAIL random_data job%0d: got pos=%0d nrm=%0d bad=%0d expected %0d %0d 0", j, pC.size(), nC.size(), badD, n, n);
            end
            checks++;
            if (badT != 0 || skew != 0) begin
                errors++;
                $display("[TB] FAIL random_timing job%0d: got late=%0d skew=%0d expected 0 0", j, badT, skew);
            end
            checks++;
            if (dC.size() != 1 || nC.size() == 0 || dC[0] != nC[$] + 1 || bC.size() == 0 || bC[0] != t0 + 1 || bC[$] != dC[0] || bC.size() != dC[0] - t0) begin
                errors++;
                $display("[TB] FAIL random_done job%0d: got done=%0d busy=%0d expected 1 done after last normal, busy through it", j, dC.size(), bC.size());
            end
            giveBack(n - got);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start_in = 1'b0;
        bus.base_addr_in = '0;
        bus.tri_count_in = '0;
        bus.consumed_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_zero();
        test_credit_stall();
        test_saturate();
        test_simultaneous();
        test_reset_mid_job();
        test_restart();
        test_random_jobs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/triangle_streamer.md
TRIANGLE_STREAMER -- requirements
Module: triangle_streamer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 1024, downstream triangle_fifo capacity in entries (sets the initial credit count).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, mesh memory word-address width.
REQ-003 The block SHALL have parameter MEM_LATENCY, default 2, fixed read latency of the mesh memory in cycles.
REQ-004 The block SHALL have these ports:
- clk_in, input, 1: the single clock; the reset is synchronous and active-high.
- rst_in, input, 1: synchronous active-high reset.
- start_in, input, 1: job start pulse.
- base_addr_in, input, ADDR_WIDTH: first word of the mesh; sampled on start.
- tri_count_in, input, 16: triangles in the job; sampled on start.
- mem_en_out, output, 1: mesh memory read strobe.
- mem_addr_out, output, ADDR_WIDTH: mesh memory read address.
- mem_data_in, input, 128: mesh memory read data.
- position_valid_out, output, 1: position word strobe to the FIFO.
- position_out, output, 4x32: position, taken from word0.
- normal_valid_out, output, 1: normal strobe to the FIFO.
- normal_out, output, 3x32: word1[127:32].
- material_valid_out, output, 1: material strobe to the FIFO.
- material_out, output, 12: word1[11:0].
- consumed_in, input, 1: the FIFO popped one triangle (its valid_out && ready_in).
- busy_out, output, 1: a job is in progress.
- done_out, output, 1: one-cycle pulse at job completion.

Function
REQ-005 Triangle i of a job SHALL occupy word0 = base+2i (position) and word1 = base+2i+1 (normal at [127:32], material at [11:0]); address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-006 The FSM SHALL have three states:
- IDLE: on start_in with tri_count_in > 0, go to FETCH; with tri_count_in == 0, pulse done_out next cycle and remain in IDLE.
- FETCH: issue reads; go to DRAIN after word1 of the last triangle is issued.
- DRAIN: wait for in-flight data; return to IDLE when the last normal/material strobe is emitted.
REQ-007 start_in SHALL be ignored outside IDLE.
REQ-008 Reads SHALL be issued at one word per cycle: word0 is issued in a cycle with mem_en_out=1; word1 SHALL be issued in the immediately following cycle, without a gap.
REQ-009 A word presented in cycle t SHALL be captured from mem_data_in in cycle t+MEM_LATENCY.
REQ-010 Word-type tags SHALL be tracked in a MEM_LATENCY-deep pipeline.
REQ-011 All stream outputs SHALL be registered: position_valid_out is high in cycle t+MEM_LATENCY+1 for word0 issued in cycle t, and normal_valid_out and material_valid_out are both high one cycle later.
REQ-012 Each valid SHALL be a single-cycle strobe; there is no backpressure on the stream outputs.
REQ-013 The credit counter (width clog2(FIFO_DEPTH)+1) SHALL reset to FIFO_DEPTH and SHALL NOT be reloaded by start.
REQ-014 The credit counter SHALL decrement on each word0 issue and increment on each consumed_in; when both occur in the same cycle, the count SHALL be unchanged.
REQ-015 consumed_in while credits == FIFO_DEPTH SHALL be ignored (saturate).
REQ-016 word0 SHALL be issued only when credits != 0; otherwise FETCH stalls with mem_en_out=0.
REQ-017 Job timing: with start in cycle 0, the first mem_en_out SHALL be in cycle 1.
REQ-018 busy_out SHALL be high from cycle 1 until the done_out cycle inclusive.
REQ-019 done_out SHALL pulse in the cycle after the last normal_valid_out.

Reset
REQ-020 In the cycle after rst_in, the block SHALL be in IDLE with all outputs 0 and credits = FIFO_DEPTH.
REQ-021 Reset SHALL clear the tag pipeline, so reads in flight at reset produce no strobes afterwards.
REQ-022 rst_in SHALL take priority over start_in and consumed_in.

Verification
REQ-023 Single triangle: N=1, base=0x0010, start in cycle 0 -> mem_addr 0x0010 in cycle 1 and 0x0011 in cycle 2; position_valid with word0 in cycle 4; normal/material valid in cycle 5; done_out in cycle 6; busy low in cycle 7.
REQ-024 Zero count: N=0 -> done_out in cycle 1; mem_en_out, busy_out and all valids stay 0.
REQ-025 Credit stall: FIFO_DEPTH=4, N=6, no consumed_in -> exactly 4 position strobes, then mem_en_out stays 0. Pulsing consumed_in twice -> 2 more triangles emitted, then done_out.
REQ-026 Simultaneous events: with credits=1, consumed_in in the same cycle as a word0 issue -> credits remain 1 and the next triangle issues without a stall.
REQ-027 Reset mid-job: N=8, rst_in in cycle 3 -> in cycle 4 all outputs are 0; no stale valids follow; credits=FIFO_DEPTH.
REQ-028 Restart: start_in pulsed while busy -> ignored, and addresses continue unchanged.
